regs_bank: RTL and testbench
============================

# regs_bank

Parametrised control/status register bank for a configurable number of ports. Generalises the two-port control block: N per-port control registers, one global status register, sticky W1C error flags with saturating counters, interrupt generation and decode-error response. Sits between the host register bus (req/ack, one-cycle latency) and the port datapaths, which consume `cfg_port_enable`/`cfg_port_id` and report `cfg_ctrl_err`/`cfg_ctrl_idle`.

## Interface
- `NUM_PORTS`, 2: port count, legal 1..16
- `ID_W`, 2: port-id field width, legal 1..4
- `ADDR_SIZE_P`, 5: address width, must be ≥ clog2(NUM_PORTS+1)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req` in 1: request strobe, one cycle per access
- `rd_wr` in 1: 1 = read, 0 = write
- `addr` in ADDR_SIZE_P: register address
- `write_val` in 32: write data
- `read_val` out 32: read data, valid with `ack`
- `ack` out 1: one-cycle access completion pulse
- `resp_err` out 1: decode error, valid with `ack`
- `cfg_ctrl_err` in NUM_PORTS: per-port error event pulse
- `cfg_ctrl_idle` in NUM_PORTS: per-port live idle status
- `cfg_port_enable` out NUM_PORTS: per-port enable
- `cfg_port_id` out NUM_PORTS*ID_W: flattened ids, port p at [p*ID_W +: ID_W]
- `irq` out 1: registered interrupt

## Operation
- Map: addr p (0..NUM_PORTS-1) = control reg of port p; addr NUM_PORTS = global status; any other addr = unmapped.
- Control reg bits: [0] enable RW; [1] err_sticky W1C; [2] idle RO (live `cfg_ctrl_idle[p]`); [3] irq_en RW; [4 +: ID_W] port_id RW; [15:8] err_cnt RO; rest read 0, writes ignored.
- err_sticky set on `cfg_ctrl_err[p]`; err_cnt increments per event, saturates at 255.
- Writing 1 to bit 1 clears err_sticky and err_cnt. Same-cycle err event and clear: sticky ends 1, err_cnt ends 1.
- Global reg: [NUM_PORTS-1:0] err_sticky summary RO; [31:24] decode_err_cnt RO, saturating 255. Write with write_val[31]=1 clears decode_err_cnt; other write bits ignored. Same-cycle decode error and clear: count ends 1.
- Unmapped access: `ack`=1, `resp_err`=1, `read_val`=0, no state change, decode_err_cnt increments.
- `irq` = OR over p of (err_sticky[p] & irq_en[p]), registered.
- Reset values: enable 0, irq_en 0, port_id = p mod 2^ID_W, err_sticky 0, err_cnt 0, decode_err_cnt 0; `ack`, `resp_err`, `read_val`, `irq` all 0.

## Timing
- `req` sampled at edge N; `ack`/`read_val`/`resp_err` asserted for exactly cycle N+1; `read_val` 0 when `ack`=0.
- Back-to-back `req` every cycle allowed, no stall; each gets its own ack one cycle later.
- Write at N updates register and `cfg_*` outputs visible at N+1; read at N+1 returns written value.
- Read returns register state before the cycle-N update; idle bit is `cfg_ctrl_idle` sampled at N.
- `cfg_ctrl_err` event at N visible in register/read at N+1; `irq` rises at N+2.
- `reset` high at any edge forces reset values next cycle, discarding any in-flight ack; `req` during reset ignored.

## Structure
- Package `regs_bank_pkg`: bit-position constants (EN_BIT, ERR_BIT, IDLE_BIT, IRQEN_BIT, ID_LSB, CNT_LSB, DEC_CNT_LSB), CNT_W=8, saturating-increment function.
- Sub-module `regs_bank_port`: one port's control register, sticky/counter logic and irq term; generate-instantiated NUM_PORTS times. Top holds decode, global reg, read mux, ack/irq registers.

## Test plan
- Reset, read addrs 0,1 (NUM_PORTS=2, ID_W=2) -> read_val 0x00000000 and 0x00000010, ack at N+1, enable=00, cfg_port_id=0b0100.
- Write 0x39 to addr 1, read addr 1 next cycle -> enable[1]=1, irq_en=1, port_id=3, read_val 0x39.
- Pulse cfg_ctrl_err[0] 300 times, read addr 0 -> err_cnt 255, bit1=1; write 0x2 with concurrent err pulse -> read err_cnt 1, bit1 1.
- irq_en[0]=1, one err pulse at N -> irq 1 at N+2; W1C clears -> irq 0 two cycles after clear write.
- Read addr 7 -> ack, resp_err=1, read_val 0; global reg [31:24]=1; write 0x80000000 to addr 2 -> count 0.
- Assert reset during back-to-back requests -> no ack following the reset cycle, all outputs at reset values.

Source files
------------

// File: rtl/regs_bank_pkg.sv
// Shared field positions, counter width and saturating increment for the
// port control/status register bank.
package regs_bank_pkg;

  localparam int EN_BIT      = 0;
  localparam int ERR_BIT     = 1;
  localparam int IDLE_BIT    = 2;
  localparam int IRQEN_BIT   = 3;
  localparam int ID_LSB      = 4;
  localparam int CNT_LSB     = 8;
  localparam int DEC_CNT_LSB = 24;
  localparam int DEC_CLR_BIT = 31;
  localparam int CNT_W       = 8;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/regs_bank_port.sv
// One port's control register: RW enable/irq_en/port_id, W1C sticky error
// flag with a saturating event counter, and this port's interrupt term.
module regs_bank_port
  import regs_bank_pkg::*;
#(
  parameter int ID_W     = 2,
  parameter int PORT_IDX = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wrEn_i,
  input  logic [31:0]     writeVal_i,
  input  logic            errEvent_i,
  input  logic            idle_i,
  output logic [31:0]     regVal_o,
  output logic            enable_o,
  output logic [ID_W-1:0] portId_o,
  output logic            errSticky_o,
  output logic            irqTerm_o
);

  logic             enable_q, enable_d;
  logic             irqEn_q, irqEn_d;
  logic [ID_W-1:0]  portId_q, portId_d;
  logic             errSticky_q, errSticky_d;
  logic [CNT_W-1:0] errCnt_q, errCnt_d;
  logic             clearErr;
  logic             unusedWrBits;

  assign unusedWrBits = ^writeVal_i;

  // An error event wins over a simultaneous clear, leaving a count of one.
  always_comb begin
    clearErr    = wrEn_i & writeVal_i[ERR_BIT];
    enable_d    = enable_q;
    irqEn_d     = irqEn_q;
    portId_d    = portId_q;
    errSticky_d = errSticky_q;
    errCnt_d    = errCnt_q;
    if (wrEn_i) begin
      enable_d = writeVal_i[EN_BIT];
      irqEn_d  = writeVal_i[IRQEN_BIT];
      portId_d = writeVal_i[ID_LSB +: ID_W];
    end
    if (errEvent_i) begin
      errSticky_d = 1'b1;
      errCnt_d    = clearErr ? CNT_W'(1) : satInc(errCnt_q);
    end else if (clearErr) begin
      errSticky_d = 1'b0;
      errCnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= 1'b0;
      irqEn_q     <= 1'b0;
      portId_q    <= ID_W'(PORT_IDX);
      errSticky_q <= 1'b0;
      errCnt_q    <= '0;
    end else begin
      enable_q    <= enable_d;
      irqEn_q     <= irqEn_d;
      portId_q    <= portId_d;
      errSticky_q <= errSticky_d;
      errCnt_q    <= errCnt_d;
    end
  end

  always_comb begin
    regVal_o                      = '0;
    regVal_o[EN_BIT]              = enable_q;
    regVal_o[ERR_BIT]             = errSticky_q;
    regVal_o[IDLE_BIT]            = idle_i;
    regVal_o[IRQEN_BIT]           = irqEn_q;
    regVal_o[ID_LSB +: ID_W]      = portId_q;
    regVal_o[CNT_LSB +: CNT_W]    = errCnt_q;
  end

  assign enable_o    = enable_q;
  assign portId_o    = portId_q;
  assign errSticky_o = errSticky_q;
  assign irqTerm_o   = errSticky_q & irqEn_q;

endmodule

// File: rtl/regs_bank.sv
// Parametrised per-port control/status register bank with a global status
// register, decode-error accounting and a registered interrupt.
module regs_bank
  import regs_bank_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ID_W        = 2,
  parameter int ADDR_SIZE_P = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      rd_wr,
  input  logic [ADDR_SIZE_P-1:0]    addr,
  input  logic [31:0]               write_val,
  output logic [31:0]               read_val,
  output logic                      ack,
  output logic                      resp_err,
  input  logic [NUM_PORTS-1:0]      cfg_ctrl_err,
  input  logic [NUM_PORTS-1:0]      cfg_ctrl_idle,
  output logic [NUM_PORTS-1:0]      cfg_port_enable,
  output logic [NUM_PORTS*ID_W-1:0] cfg_port_id,
  output logic                      irq
);

  logic [31:0]          portReg [NUM_PORTS];
  logic [NUM_PORTS-1:0] portWr, errSticky, irqTerm;
  logic                 isGlobal, isMapped, decErr, decClr;
  logic [CNT_W-1:0]     decCnt_q, decCnt_d;
  logic [31:0]          globalVal, rdData, readVal_q, readVal_d;
  logic                 ack_q, respErr_q, irq_q;

  assign isGlobal = (addr == ADDR_SIZE_P'(NUM_PORTS));
  assign isMapped = (addr <= ADDR_SIZE_P'(NUM_PORTS));
  assign decErr   = req & ~isMapped;
  assign decClr   = req & ~rd_wr & isGlobal & write_val[DEC_CLR_BIT];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    assign portWr[p] = req & ~rd_wr & (addr == ADDR_SIZE_P'(p));

    regs_bank_port #(
      .ID_W     (ID_W),
      .PORT_IDX (p)
    ) uPort (
      .clk         (clk),
      .reset       (reset),
      .wrEn_i      (portWr[p]),
      .writeVal_i  (write_val),
      .errEvent_i  (cfg_ctrl_err[p]),
      .idle_i      (cfg_ctrl_idle[p]),
      .regVal_o    (portReg[p]),
      .enable_o    (cfg_port_enable[p]),
      .portId_o    (cfg_port_id[p*ID_W +: ID_W]),
      .errSticky_o (errSticky[p]),
      .irqTerm_o   (irqTerm[p])
    );
  end

  always_comb begin
    globalVal                          = '0;
    globalVal[NUM_PORTS-1:0]           = errSticky;
    globalVal[DEC_CNT_LSB +: CNT_W]    = decCnt_q;
  end

  // Unmapped addresses fall through to zero read data.
  always_comb begin
    rdData = '0;
    if (isGlobal) begin
      rdData = globalVal;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (addr == ADDR_SIZE_P'(p)) begin
        rdData = portReg[p];
      end
    end
    readVal_d = (req & rd_wr) ? rdData : '0;
  end

  always_comb begin
    decCnt_d = decCnt_q;
    if (decErr) begin
      decCnt_d = satInc(decCnt_q);
    end else if (decClr) begin
      decCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      respErr_q <= 1'b0;
      readVal_q <= '0;
      irq_q     <= 1'b0;
      decCnt_q  <= '0;
    end else begin
      ack_q     <= req;
      respErr_q <= decErr;
      readVal_q <= readVal_d;
      irq_q     <= |irqTerm;
      decCnt_q  <= decCnt_d;
    end
  end

  assign ack      = ack_q;
  assign resp_err = respErr_q;
  assign read_val = readVal_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_regs_bank.sv
// Self-checking bench for regs_bank (2 ports, 2-bit ids): directed vectors,
// a spec-level register model compared every cycle, plus literal checks.
module tb_regs_bank;

  localparam int NP  = 2;
  localparam int IDW = 2;
  localparam int AW  = 5;

  logic            clk;
  logic            reset;
  logic            req;
  logic            rd_wr;
  logic [AW-1:0]   addr;
  logic [31:0]     write_val;
  logic [31:0]     read_val;
  logic            ack;
  logic            resp_err;
  logic [NP-1:0]   cfg_ctrl_err;
  logic [NP-1:0]   cfg_ctrl_idle;
  logic [NP-1:0]   cfg_port_enable;
  logic [NP*IDW-1:0] cfg_port_id;
  logic            irq;

  int testsRun = 0;
  int testsFailed = 0;

  regs_bank #(
    .NUM_PORTS   (NP),
    .ID_W        (IDW),
    .ADDR_SIZE_P (AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .rd_wr           (rd_wr),
    .addr            (addr),
    .write_val       (write_val),
    .read_val        (read_val),
    .ack             (ack),
    .resp_err        (resp_err),
    .cfg_ctrl_err    (cfg_ctrl_err),
    .cfg_ctrl_idle   (cfg_ctrl_idle),
    .cfg_port_enable (cfg_port_enable),
    .cfg_port_id     (cfg_port_id),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Model state: plain integers per field, updated by the register rules.
  int   mEnable [NP];
  int   mIrqEn  [NP];
  int   mId     [NP];
  int   mSticky [NP];
  int   mCnt    [NP];
  int   mDecCnt;
  bit   modelValid = 1'b0;
  bit   expAck, expResp, expIrq, expIsRead;
  logic [31:0] expRead;

  function automatic logic [31:0] portWord(input int p);
    return 32'(mEnable[p]) | (32'(mSticky[p]) << 1) | (32'(cfg_ctrl_idle[p]) << 2)
         | (32'(mIrqEn[p]) << 3) | (32'(mId[p]) << 4) | (32'(mCnt[p]) << 8);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        mEnable[p] = 0; mIrqEn[p] = 0; mId[p] = p % (1 << IDW);
        mSticky[p] = 0; mCnt[p] = 0;
      end
      mDecCnt = 0;
      expAck = 0; expResp = 0; expIrq = 0; expIsRead = 0; expRead = '0;
      modelValid = 1'b1;
    end else begin
      int a;
      a = int'(addr);
      expIrq = 0;
      for (int p = 0; p < NP; p++)
        if (mSticky[p] == 1 && mIrqEn[p] == 1) expIrq = 1;
      expAck    = req;
      expIsRead = req && rd_wr;
      expResp   = req && (a > NP);
      expRead   = '0;
      if (req && rd_wr) begin
        if (a < NP) expRead = portWord(a);
        else if (a == NP) begin
          expRead = 32'(mDecCnt) << 24;
          for (int p = 0; p < NP; p++) expRead = expRead | (32'(mSticky[p]) << p);
        end
      end
      for (int p = 0; p < NP; p++) begin
        bit isWr, clr;
        isWr = req && !rd_wr && (a == p);
        clr  = isWr && write_val[1];
        if (isWr) begin
          mEnable[p] = int'(write_val[0]);
          mIrqEn[p]  = int'(write_val[3]);
          mId[p]     = int'(write_val[5:4]);
        end
        if (cfg_ctrl_err[p]) begin
          mSticky[p] = 1;
          mCnt[p]    = clr ? 1 : ((mCnt[p] < 255) ? mCnt[p] + 1 : 255);
        end else if (clr) begin
          mSticky[p] = 0;
          mCnt[p]    = 0;
        end
      end
      if (req && a > NP) mDecCnt = (mDecCnt < 255) ? mDecCnt + 1 : 255;
      else if (req && !rd_wr && a == NP && write_val[31]) mDecCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      logic [NP-1:0]     expEn;
      logic [NP*IDW-1:0] expId;
      for (int p = 0; p < NP; p++) begin
        expEn[p]            = 1'(mEnable[p]);
        expId[p*IDW +: IDW] = IDW'(mId[p]);
      end
      checkOutput("model ack", 32'(ack), 32'(expAck));
      checkOutput("model resp_err", 32'(resp_err), 32'(expResp));
      checkOutput("model irq", 32'(irq), 32'(expIrq));
      checkOutput("model enable", 32'(cfg_port_enable), 32'(expEn));
      checkOutput("model port_id", 32'(cfg_port_id), 32'(expId));
      if (!expAck || expIsRead)
        checkOutput("model read_val", read_val, expRead);
    end
  end

  task automatic applyStimulus(input bit r, input bit rw, input int a,
                               input logic [31:0] wv, input logic [NP-1:0] err);
    req = r; rd_wr = rw; addr = AW'(a); write_val = wv; cfg_ctrl_err = err;
    @(posedge clk);
    #1;
    req = 1'b0; cfg_ctrl_err = '0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; rd_wr = 1'b0; addr = '0; write_val = '0;
    cfg_ctrl_err = '0; cfg_ctrl_idle = '0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1, 0, 1, 32'hFFFF_FFFF, 2'b11);
    reset = 1'b0;
    checkOutput("reset enable", 32'(cfg_port_enable), 32'h0);
    checkOutput("reset port_id", 32'(cfg_port_id), 32'h4);
    checkOutput("reset ack", 32'(ack), 32'h0);
    checkOutput("reset irq", 32'(irq), 32'h0);

    applyStimulus(1, 1, 0, '0, '0);
    checkOutput("rd0 ack", 32'(ack), 32'h1);
    checkOutput("rd0 val", read_val, 32'h0);
    applyStimulus(1, 1, 1, '0, '0);
    checkOutput("rd1 val", read_val, 32'h10);
    cfg_ctrl_idle = 2'b10;
    applyStimulus(1, 1, 1, '0, '0);
    checkOutput("rd1 idle", read_val, 32'h14);
    cfg_ctrl_idle = 2'b00;
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("idle ack", 32'(ack), 32'h0);

    applyStimulus(1, 0, 1, 32'h39, '0);
    checkOutput("wr1 enable", 32'(cfg_port_enable), 32'h2);
    checkOutput("wr1 port_id", 32'(cfg_port_id), 32'hC);
    applyStimulus(1, 1, 1, '0, '0);
    checkOutput("wr1 readback", read_val, 32'h39);

    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 0, '0, 2'b01);
    applyStimulus(1, 1, 0, '0, '0);
    checkOutput("err saturate", read_val, 32'hFF02);
    applyStimulus(1, 1, 2, '0, '0);
    checkOutput("global sticky", read_val, 32'h1);
    applyStimulus(1, 0, 0, 32'h2, 2'b01);
    applyStimulus(1, 1, 0, '0, '0);
    checkOutput("clear vs err", read_val, 32'h102);

    applyStimulus(1, 0, 0, 32'h0A, '0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("irq quiet", 32'(irq), 32'h0);
    applyStimulus(0, 0, 0, '0, 2'b01);
    checkOutput("irq N+1", 32'(irq), 32'h0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("irq N+2", 32'(irq), 32'h1);
    applyStimulus(1, 0, 0, 32'h0A, '0);
    checkOutput("irq after clr +1", 32'(irq), 32'h1);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("irq after clr +2", 32'(irq), 32'h0);

    applyStimulus(1, 1, 7, '0, '0);
    checkOutput("unmapped ack", 32'(ack), 32'h1);
    checkOutput("unmapped resp_err", 32'(resp_err), 32'h1);
    checkOutput("unmapped read_val", read_val, 32'h0);
    applyStimulus(1, 1, 2, '0, '0);
    checkOutput("dec cnt 1", read_val, 32'h0100_0000);
    applyStimulus(1, 0, 2, 32'h8000_0000, '0);
    applyStimulus(1, 1, 2, '0, '0);
    checkOutput("dec cnt cleared", read_val, 32'h0);
    applyStimulus(1, 0, 9, 32'hFFFF_FFFF, '0);
    applyStimulus(1, 1, 2, '0, '0);
    checkOutput("unmapped write", read_val, 32'h0100_0000);

    applyStimulus(1, 0, 0, 32'h3D, '0);
    applyStimulus(1, 1, 0, '0, 2'b01);
    checkOutput("port0 0x3D", read_val, 32'h39);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("irq before reset", 32'(irq), 32'h1);
    applyStimulus(1, 1, 1, '0, '0);
    reset = 1'b1;
    applyStimulus(1, 1, 0, '0, '0);
    checkOutput("mid-reset ack", 32'(ack), 32'h0);
    checkOutput("mid-reset read_val", read_val, 32'h0);
    checkOutput("mid-reset enable", 32'(cfg_port_enable), 32'h0);
    checkOutput("mid-reset port_id", 32'(cfg_port_id), 32'h4);
    checkOutput("mid-reset irq", 32'(irq), 32'h0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("post-reset ack", 32'(ack), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
